riscv_muldiv_unit: RTL and testbench

- Parametrised iterative RV32M multiply/divide unit that sits beside the integer ALU in the core's execute stage.
- Executes mul, mulh, mulhsu, mulhu, div, divu, rem and remu, selected by op_funct3.
- Stalls the execute stage through is_mul_wait until the result is ready.
- Compared with the previous unit, it adds configurable radix and width, an optional single-cycle multiplier, single-cycle special-case division, and a div/rem result cache that fuses back-to-back div/rem pairs.

---
 rtl/riscv_muldiv_unit_if.sv | 21 ++
 rtl/riscv_muldiv_unit.sv | 217 +++++++++++++++++++++
 tb/tb_riscv_muldiv_unit.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/riscv_muldiv_unit_if.sv
// Execute-stage handshake between the core and the RV32M multiply/divide unit.
interface riscv_muldiv_unit_if #(
  parameter int XLEN = 32
);
  logic            enabled;
  logic [2:0]      op_funct3;
  logic [XLEN-1:0] reg_s1;
  logic [XLEN-1:0] reg_s2;
  logic [XLEN-1:0] rd_mul;
  logic            is_mul_wait;

  modport master (
    output enabled, op_funct3, reg_s1, reg_s2,
    input  rd_mul, is_mul_wait
  );

  modport slave (
    input  enabled, op_funct3, reg_s1, reg_s2,
    output rd_mul, is_mul_wait
  );
endinterface

// File: rtl/riscv_muldiv_unit.sv
// Iterative RV32M multiply/divide unit with radix/width parameters, optional
// single-cycle multiplier, zero-wait special-case division and a div/rem cache.
module riscv_muldiv_unit #(
  parameter int XLEN       = 32,
  parameter int RADIX_BITS = 1,
  parameter int FAST_MUL   = 0
) (
  input  logic               clock,
  input  logic               reset,
  riscv_muldiv_unit_if.slave bus
);
  localparam int STEPS = XLEN / RADIX_BITS;
  localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [CW-1:0]   CNT_INIT = CW'(STEPS - 1);
  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  // state | meaning
  // IDLE  | accept op; fast paths answer here with no wait
  // BUSY  | RADIX_BITS bits retired per cycle, counter counts down
  // DONE  | sign-corrected result presented for one cycle
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   opb_q, opb_d;
  logic [XLEN-1:0]   raw_a_q, raw_a_d, raw_b_q, raw_b_d;
  logic [2:0]        op_q, op_d;
  logic              neg_q, neg_d, neg_rem_q, neg_rem_d;

  logic              cache_v_q, c_sgn_q;
  logic [XLEN-1:0]   c_s1_q, c_s2_q, c_quo_q, c_rem_q;

  logic              fill, fill_sgn;
  logic [XLEN-1:0]   fill_s1, fill_s2, fill_quo, fill_rem;
  logic              wait_c;
  logic [XLEN-1:0]   rd_c;

  logic              in_div, in_sdiv, s1_sg, s2_sg, a_neg, b_neg;
  logic [XLEN-1:0]   mag_a, mag_b;
  logic              div_zero, div_ovf, cache_hit, fast;
  logic [XLEN-1:0]   fast_quo, fast_rem;

  always_comb begin
    in_div    = bus.op_funct3[2];
    in_sdiv   = in_div & ~bus.op_funct3[0];
    s1_sg     = in_div ? in_sdiv
                       : (bus.op_funct3[1:0] == 2'd1 || bus.op_funct3[1:0] == 2'd2);
    s2_sg     = in_div ? in_sdiv : (bus.op_funct3[1:0] == 2'd1);
    a_neg     = s1_sg & bus.reg_s1[XLEN-1];
    b_neg     = s2_sg & bus.reg_s2[XLEN-1];
    mag_a     = a_neg ? -bus.reg_s1 : bus.reg_s1;
    mag_b     = b_neg ? -bus.reg_s2 : bus.reg_s2;
    div_zero  = in_div && (bus.reg_s2 == '0);
    div_ovf   = in_sdiv && (bus.reg_s1 == MOST_NEG) && (bus.reg_s2 == '1);
    cache_hit = in_div && cache_v_q && (c_s1_q == bus.reg_s1) &&
                (c_s2_q == bus.reg_s2) && (c_sgn_q == in_sdiv);
    fast      = div_zero || div_ovf || cache_hit;
    if (div_zero) begin
      fast_quo = '1;
      fast_rem = bus.reg_s1;
    end else if (div_ovf) begin
      fast_quo = bus.reg_s1;
      fast_rem = '0;
    end else begin
      fast_quo = c_quo_q;
      fast_rem = c_rem_q;
    end
  end

  // One iteration step: acc holds {partial product, multiplier} for mul and
  // {partial remainder, dividend/quotient} for div.
  logic [XLEN+RADIX_BITS-1:0] mul_sum;
  logic [2*XLEN-1:0]          mul_next, div_next;
  logic [XLEN:0]              div_trial;
  logic [XLEN-1:0]            div_rem, div_quo;

  always_comb begin
    mul_sum  = {{RADIX_BITS{1'b0}}, acc_q[2*XLEN-1:XLEN]}
             + ({{RADIX_BITS{1'b0}}, opb_q} * {{XLEN{1'b0}}, acc_q[RADIX_BITS-1:0]});
    mul_next = {mul_sum, acc_q[XLEN-1:RADIX_BITS]};
    div_rem   = acc_q[2*XLEN-1:XLEN];
    div_quo   = acc_q[XLEN-1:0];
    div_trial = '0;
    for (int i = 0; i < RADIX_BITS; i++) begin
      div_trial = {div_rem, div_quo[XLEN-1]};
      div_quo   = {div_quo[XLEN-2:0], 1'b0};
      if (div_trial >= {1'b0, opb_q}) begin
        div_trial  = div_trial - {1'b0, opb_q};
        div_quo[0] = 1'b1;
      end
      div_rem = div_trial[XLEN-1:0];
    end
    div_next = {div_rem, div_quo};
  end

  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix, res;

  always_comb begin
    prod_fix = neg_q ? -acc_q : acc_q;
    quo_fix  = neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    rem_fix  = neg_rem_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
    if (op_q[2]) res = op_q[1] ? rem_fix : quo_fix;
    else         res = (op_q[1:0] == 2'd0) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    opb_d     = opb_q;
    raw_a_d   = raw_a_q;
    raw_b_d   = raw_b_q;
    op_d      = op_q;
    neg_d     = neg_q;
    neg_rem_d = neg_rem_q;
    wait_c    = 1'b0;
    rd_c      = '0;
    fill      = 1'b0;
    fill_sgn  = 1'b0;
    fill_s1   = '0;
    fill_s2   = '0;
    fill_quo  = '0;
    fill_rem  = '0;
    case (state_q)
      IDLE: begin
        if (bus.enabled) begin
          if (fast) begin
            rd_c     = bus.op_funct3[1] ? fast_rem : fast_quo;
            fill     = div_zero || div_ovf;
            fill_sgn = in_sdiv;
            fill_s1  = bus.reg_s1;
            fill_s2  = bus.reg_s2;
            fill_quo = fast_quo;
            fill_rem = fast_rem;
          end else begin
            wait_c    = 1'b1;
            op_d      = bus.op_funct3;
            raw_a_d   = bus.reg_s1;
            raw_b_d   = bus.reg_s2;
            neg_d     = a_neg ^ b_neg;
            neg_rem_d = a_neg;
            opb_d     = mag_b;
            if (!in_div && FAST_MUL != 0) begin
              acc_d   = {{XLEN{1'b0}}, mag_a} * {{XLEN{1'b0}}, mag_b};
              state_d = DONE;
            end else begin
              acc_d   = {{XLEN{1'b0}}, mag_a};
              cnt_d   = CNT_INIT;
              state_d = BUSY;
            end
          end
        end
      end
      BUSY: begin
        wait_c = 1'b1;
        acc_d  = op_q[2] ? div_next : mul_next;
        cnt_d  = cnt_q - 1'b1;
        if (cnt_q == '0) state_d = DONE;
      end
      DONE: begin
        rd_c     = res;
        state_d  = IDLE;
        fill     = op_q[2];
        fill_sgn = ~op_q[0];
        fill_s1  = raw_a_q;
        fill_s2  = raw_b_q;
        fill_quo = quo_fix;
        fill_rem = rem_fix;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      opb_q     <= '0;
      raw_a_q   <= '0;
      raw_b_q   <= '0;
      op_q      <= '0;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
      cache_v_q <= 1'b0;
      c_sgn_q   <= 1'b0;
      c_s1_q    <= '0;
      c_s2_q    <= '0;
      c_quo_q   <= '0;
      c_rem_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      opb_q     <= opb_d;
      raw_a_q   <= raw_a_d;
      raw_b_q   <= raw_b_d;
      op_q      <= op_d;
      neg_q     <= neg_d;
      neg_rem_q <= neg_rem_d;
      if (fill) begin
        cache_v_q <= 1'b1;
        c_sgn_q   <= fill_sgn;
        c_s1_q    <= fill_s1;
        c_s2_q    <= fill_s2;
        c_quo_q   <= fill_quo;
        c_rem_q   <= fill_rem;
      end
    end
  end

  // Outputs are forced quiet while reset is held so an aborted op never leaks.
  assign bus.is_mul_wait = reset & wait_c;
  assign bus.rd_mul      = reset ? rd_c : '0;
endmodule

// File: tb/tb_riscv_muldiv_unit.sv
// Scoreboard bench for riscv_muldiv_unit: three configurations driven one at a time.
module tb_riscv_muldiv_unit;
  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        en    = 1'b0;
  logic [2:0]  f3    = 3'd0;
  logic [31:0] s1    = '0;
  logic [31:0] s2    = '0;
  int          sel   = 0;

  always #5 clock = ~clock;

  riscv_muldiv_unit_if #(.XLEN(32)) if_a ();
  riscv_muldiv_unit_if #(.XLEN(32)) if_b ();
  riscv_muldiv_unit_if #(.XLEN(32)) if_c ();

  assign if_a.enabled = en && (sel == 0);
  assign if_b.enabled = en && (sel == 1);
  assign if_c.enabled = en && (sel == 2);
  assign if_a.op_funct3 = f3;  assign if_a.reg_s1 = s1;  assign if_a.reg_s2 = s2;
  assign if_b.op_funct3 = f3;  assign if_b.reg_s1 = s1;  assign if_b.reg_s2 = s2;
  assign if_c.op_funct3 = f3;  assign if_c.reg_s1 = s1;  assign if_c.reg_s2 = s2;

  riscv_muldiv_unit #(.XLEN(32), .RADIX_BITS(1), .FAST_MUL(0)) u_a (
    .clock(clock), .reset(reset), .bus(if_a.slave));
  riscv_muldiv_unit #(.XLEN(32), .RADIX_BITS(4), .FAST_MUL(0)) u_b (
    .clock(clock), .reset(reset), .bus(if_b.slave));
  riscv_muldiv_unit #(.XLEN(32), .RADIX_BITS(1), .FAST_MUL(1)) u_c (
    .clock(clock), .reset(reset), .bus(if_c.slave));

  logic        cur_wait;
  logic [31:0] cur_rd;
  assign cur_wait = (sel == 0) ? if_a.is_mul_wait : (sel == 1) ? if_b.is_mul_wait : if_c.is_mul_wait;
  assign cur_rd   = (sel == 0) ? if_a.rd_mul      : (sel == 1) ? if_b.rd_mul      : if_c.rd_mul;

  typedef struct packed {
    logic [31:0] res;
    int          waits;
    int          tag;
  } exp_t;

  exp_t sb[$];
  int   n_chk    = 0;
  int   n_fail   = 0;
  int   wait_cnt = 0;
  int   tag_cnt  = 0;
  bit   end_req  = 1'b0;
  bit   end_ack  = 1'b0;

  task automatic check(input string name, input int tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (op %0d): got 0x%08h, expected 0x%08h", name, tag, act, exp);
    end
  endtask

  // Monitor: samples on the falling edge, pops one expectation per presented result.
  always @(negedge clock) begin
    exp_t e;
    if (end_req && !end_ack) begin
      check("scoreboard_drained", -1, 32'(sb.size()), 32'd0);
      end_ack = 1'b1;
    end else if (!reset) begin
      check("reset_wait", -1, {31'd0, cur_wait}, 32'd0);
      check("reset_rd",   -1, cur_rd, 32'd0);
      wait_cnt = 0;
    end else if (!en) begin
      check("idle_wait", -1, {31'd0, cur_wait}, 32'd0);
      check("idle_rd",   -1, cur_rd, 32'd0);
    end else if (cur_wait) begin
      wait_cnt++;
    end else begin
      if (sb.size() == 0) begin
        check("unexpected_result", -1, 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check("result", e.tag, cur_rd, e.res);
        check("wait_cycles", e.tag, 32'(wait_cnt), 32'(e.waits));
      end
      wait_cnt = 0;
    end
  end

  task automatic run_op(input int dut, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int waits,
                        input bit gap);
    exp_t e;
    e.res = exp; e.waits = waits; e.tag = tag_cnt;
    tag_cnt++;
    sb.push_back(e);
    sel = dut; f3 = op; s1 = a; s2 = b; en = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clock);
      if (!cur_wait) break;
    end
    if (cur_wait) begin
      $display("FAIL op_timeout (op %0d): is_mul_wait still 1, expected 0", e.tag);
      $fatal(1, "timeout");
    end
    @(posedge clock); #1;
    if (gap) begin
      en = 1'b0;
      @(posedge clock); #1;
    end
  endtask

  initial begin
    repeat (3) @(posedge clock);
    #1 reset = 1'b1;
    @(posedge clock); #1;

    // Radix-2 iterative unit
    run_op(0, 3'd0, 32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, 33, 1);
    run_op(0, 3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33, 1);
    run_op(0, 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, 1);
    run_op(0, 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, 1);
    run_op(0, 3'd4, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD, 33, 0);
    run_op(0, 3'd6, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 0,  1);
    run_op(0, 3'd7, 32'hFFFF_FFF9, 32'd2,        32'd1,         33, 1);
    run_op(0, 3'd5, 32'd5,        32'd0,        32'hFFFF_FFFF, 0,  1);
    run_op(0, 3'd7, 32'd5,        32'd0,        32'd5,         0,  1);
    run_op(0, 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0, 1);
    run_op(0, 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,        0,  1);

    // Reset in BUSY cycle 10 of div 100,7 must abort and invalidate the cache
    sel = 0; f3 = 3'd4; s1 = 32'd100; s2 = 32'd7; en = 1'b1;
    repeat (10) @(posedge clock);
    #1 reset = 1'b0;
    @(posedge clock); #1 en = 1'b0;
    @(posedge clock); #1 reset = 1'b1;
    @(posedge clock); #1;
    run_op(0, 3'd6, 32'd100, 32'd7, 32'd2,  33, 1);
    run_op(0, 3'd0, 32'd3,   32'd5, 32'd15, 33, 1);
    run_op(0, 3'd4, 32'd100, 32'd7, 32'd14, 0,  1);

    // Radix-16 unit
    run_op(1, 3'd5, 32'd100,       32'd7,        32'd14,        9, 1);
    run_op(1, 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 9, 1);

    // Single-cycle multiplier unit
    run_op(2, 3'd0, 32'd6,         32'd7,         32'd42,        1,  1);
    run_op(2, 3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1,  1);
    run_op(2, 3'd4, 32'd100,       32'd7,         32'd14,        33, 1);

    end_req = 1'b1;
    for (int i = 0; i < 10 && !end_ack; i++) @(posedge clock);
    if (!end_ack) begin
      n_chk++;
      n_fail++;
      $display("FAIL end_handshake: ack 0, expected 1");
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
